// File: rtl/dmem_responder.sv
// Word-addressed data-memory slave for the core's load/store port: synchronous
// word array, fixed read latency with a one-cycle valid pulse, sticky error flag.
module dmem_responder #(
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_memaddr,
  input  logic        i_read_en,
  input  logic        i_write_en,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_read_data,
  output logic        o_read_vd,
  output logic        o_busy,
  output logic        o_err,
  input  logic        i_err_clr
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    VALID
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        err_reg, err_next;
  logic        oor_reg, oor_next;
  logic [31:0] rd_word_reg;
  logic [31:0] mem [DEPTH];

  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          misaligned;
  logic          rd_accept;
  logic          wr_commit;
  logic          err_set;

  assign word_idx   = i_memaddr[AW+1:2];
  assign in_range   = ({1'b0, i_memaddr} < ADDR_LIMIT);
  assign misaligned = (i_memaddr[1:0] != 2'b00);
  assign rd_accept  = (state_reg == IDLE) && i_read_en;
  // A pending read owns the port, so a coincident store is discarded.
  assign wr_commit  = i_write_en && !i_read_en && in_range;
  assign err_set    = (rd_accept && (misaligned || !in_range)) ||
                      (i_write_en && (i_read_en || misaligned || !in_range));

  // Array port: write-only or read-only in any given cycle, never both.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem[word_idx] <= i_write_data;
    end
    if (rd_accept) begin
      rd_word_reg <= mem[word_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      oor_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      oor_reg   <= oor_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    oor_next   = oor_reg;
    case (state_reg)
      IDLE: begin
        if (i_read_en) begin
          oor_next   = !in_range;
          cnt_next   = 4'(READ_LAT - 1);
          state_next = (READ_LAT == 1) ? VALID : WAIT;
        end
      end
      WAIT: begin
        if (!i_read_en) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_next = VALID;
          end
        end
      end
      VALID: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A new error in the same cycle as a clear keeps the flag raised.
    if (err_set) begin
      err_next = 1'b1;
    end else if (i_err_clr) begin
      err_next = 1'b0;
    end else begin
      err_next = err_reg;
    end
  end

  assign o_read_vd   = (state_reg == VALID);
  assign o_read_data = (o_read_vd && !oor_reg) ? rd_word_reg : '0;
  assign o_busy      = (state_reg != IDLE);
  assign o_err       = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table-driven write/read vectors, a
// read-data scoreboard, and hand-written latency, abort and reset sequences.
module tb_dmem_responder;

  localparam int LAT = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic        err_clr = 1'b0;
  logic [31:0] o_read_data;
  logic        o_read_vd;
  logic        o_busy;
  logic        o_err;

  logic        rd4 = 1'b0;
  logic [31:0] data4;
  logic        vd4;
  logic        busy4;
  logic        err4;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_w;
  vec_t        vecs[6];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .READ_LAT(LAT)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_memaddr    (addr),
    .i_read_en    (re),
    .i_write_en   (we),
    .i_write_data (wdata),
    .o_read_data  (o_read_data),
    .o_read_vd    (o_read_vd),
    .o_busy       (o_busy),
    .o_err        (o_err),
    .i_err_clr    (err_clr)
  );

  dmem_responder #(.DEPTH(1024), .READ_LAT(4)) u_lat4 (
    .clk          (clk),
    .rst          (rst),
    .i_memaddr    (addr),
    .i_read_en    (rd4),
    .i_write_en   (1'b0),
    .i_write_data (wdata),
    .o_read_data  (data4),
    .o_read_vd    (vd4),
    .o_busy       (busy4),
    .o_err        (err4),
    .i_err_clr    (1'b0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every pulse must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (o_read_vd) begin
      if (sb.size() == 0) begin
        check("unexpected_vd", 32'd1, 32'd0);
      end else begin
        exp_w = sb.pop_front();
        check("read_data", o_read_data, exp_w);
      end
    end else begin
      check("idle_data", o_read_data, 32'd0);
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    $display("write addr=%h data=%h", a, d);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, output int lat);
    sb.push_back(exp);
    addr = a;
    re   = 1'b1;
    lat  = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_read_vd) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      void'(sb.pop_back());
    end
    @(posedge clk);
    #1;
    re = 1'b0;
    $display("read  addr=%h expect=%h latency=%0d", a, exp, lat);
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("err_cleared", 32'(o_err), 32'd0);
  endtask

  initial begin
    int lat;
    int p1;
    int p2;
    int seen;

    vecs[0] = '{addr: 32'h0000_0010, wdata: 32'hDEAD_BEEF, exp_data: 32'hDEAD_BEEF, exp_err: 1'b0};
    vecs[1] = '{addr: 32'h0000_0000, wdata: 32'h0000_0001, exp_data: 32'h0000_0001, exp_err: 1'b0};
    vecs[2] = '{addr: 32'h0000_0FFC, wdata: 32'hCAFE_F00D, exp_data: 32'hCAFE_F00D, exp_err: 1'b0};
    vecs[3] = '{addr: 32'h0000_0046, wdata: 32'h0BAD_0046, exp_data: 32'h0BAD_0046, exp_err: 1'b1};
    vecs[4] = '{addr: 32'h0000_1000, wdata: 32'h5A5A_5A5A, exp_data: 32'h0000_0000, exp_err: 1'b1};
    vecs[5] = '{addr: 32'hFFFF_FFFC, wdata: 32'h7777_7777, exp_data: 32'h0000_0000, exp_err: 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_vd", 32'(o_read_vd), 32'd0);
    check("rst_data", o_read_data, 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].addr, vecs[i].wdata);
      do_read(vecs[i].addr, vecs[i].exp_data, lat);
      check("vec_latency", 32'(lat), 32'(LAT));
      check("vec_err", 32'(o_err), 32'(vecs[i].exp_err));
      if (vecs[i].exp_err) clr_err();
    end

    // Dropped top-of-space write must not alias onto the last word.
    do_read(32'h0000_0FFC, 32'hCAFE_F00D, lat);
    check("alias_err", 32'(o_err), 32'd0);

    // Sticky error from an out-of-range read.
    do_read(32'h0000_1000, 32'h0, lat);
    check("oor_err", 32'(o_err), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("oor_err_sticky", 32'(o_err), 32'd1);
    clr_err();

    // Back-to-back loads with the address switched in the IDLE cycle.
    do_write(32'h20, 32'h1111_1111);
    do_write(32'h24, 32'h2222_2222);
    sb.push_back(32'h1111_1111);
    sb.push_back(32'h2222_2222);
    addr = 32'h20;
    re   = 1'b1;
    p1   = -1;
    p2   = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (o_read_vd) begin
        if (p1 < 0) p1 = k;
        else if (p2 < 0) p2 = k;
      end
      @(posedge clk);
      #1;
      if (p1 == k) addr = 32'h24;
      if (p2 == k) break;
    end
    re = 1'b0;
    $display("b2b   first=%0d second=%0d", p1, p2);
    check("b2b_first", 32'(p1), 32'(LAT));
    check("b2b_spacing", 32'(p2 - p1), 32'(LAT + 1));

    // Coincident read and write: store dropped, read unaffected.
    do_write(32'h8, 32'h1234_5678);
    wdata = 32'hAAAA_5555;
    we    = 1'b1;
    do_read(32'h8, 32'h1234_5678, lat);
    we = 1'b0;
    check("rw_err", 32'(o_err), 32'd1);
    clr_err();
    do_read(32'h8, 32'h1234_5678, lat);
    check("rw_after_err", 32'(o_err), 32'd0);

    // Abort on the READ_LAT=4 instance.
    addr = 32'h10;
    rd4  = 1'b1;
    @(posedge clk);
    #1;
    rd4 = 1'b0;
    @(negedge clk);
    check("abort_busy_wait", 32'(busy4), 32'd1);
    @(negedge clk);
    check("abort_busy_idle", 32'(busy4), 32'd0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen += int'(vd4) + int'(data4 != 0);
    end
    check("abort_no_vd", 32'(seen), 32'd0);
    check("abort_err", 32'(err4), 32'd0);
    @(posedge clk);
    #1;
    $display("abort lat4 pulses=%0d", seen);

    // Reset during WAIT; nothing may emerge afterwards.
    addr = 32'h10;
    re   = 1'b1;
    @(posedge clk);
    #1;
    check("rstw_busy_before", 32'(o_busy), 32'd1);
    rst = 1'b1;
    re  = 1'b0;
    #1;
    check("rstw_busy_async", 32'(o_busy), 32'd0);
    check("rstw_vd_async", 32'(o_read_vd), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen += int'(o_read_vd) + int'(o_busy);
    end
    check("rstw_quiet", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    $display("reset during WAIT, activity after release=%0d", seen);
    do_read(32'h10, 32'hDEAD_BEEF, lat);
    check("rstw_latency", 32'(lat), 32'(LAT));

    // Error set and clear in the same cycle: set wins.
    addr    = 32'h2;
    wdata   = 32'h0000_0001;
    we      = 1'b1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    we      = 1'b0;
    err_clr = 1'b0;
    check("set_wins", 32'(o_err), 32'd1);
    $display("misaligned write with clear, err=%0d", o_err);
    clr_err();

    repeat (2) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave on the far end of the core's load/store port.
- Accepts word reads and writes from the core's memaddr, read_en, write_en and write_data outputs.
- Returns read data with a configurable latency and a one-cycle read-valid pulse, which releases the core's load-wait stall.
- Backed by an internal synchronous word array; detects misaligned and out-of-range accesses.

Parameters:
DEPTH, 1024, number of 32-bit words in the array (power of two, ≥ 4)
READ_LAT, 2, cycles from read acceptance to read-valid pulse (1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_memaddr  in  32  byte address from core
i_read_en  in  1  read request level (held by core until valid)
i_write_en  in  1  write strobe (single cycle per store)
i_write_data  in  32  store data, already lane-merged by core
o_read_data  out  32  load data, meaningful only while o_read_vd=1
o_read_vd  out  1  read-valid pulse to core
o_busy  out  1  high in WAIT or VALID state
o_err  out  1  sticky access-error flag
i_err_clr  in  1  clears o_err

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (ports clk, rst).
  - Reset drives state=IDLE, o_read_vd=0, o_read_data=0, o_busy=0, o_err=0, latency counter=0.
  - Array contents are not cleared.
- Word index = i_memaddr[log2(DEPTH)+1:2].
- In-range means i_memaddr < DEPTH*4.
- Misaligned means i_memaddr[1:0]≠0.
  - Misaligned accesses still use the word index.
  - They set o_err.
- FSM states: IDLE, WAIT, VALID.
- IDLE:
  - If i_read_en=1, latch the address and the array word into a data register.
    - Out-of-range reads latch 0 and set o_err.
  - Load counter=READ_LAT-1.
  - Go to VALID if READ_LAT=1, else go to WAIT.
- WAIT:
  - Decrement the counter; go to VALID when the counter reaches 1.
  - i_memaddr changes are ignored, since the address is already latched.
  - If i_read_en drops, abort to IDLE with no pulse.
- VALID:
  - o_read_vd=1 for exactly one cycle; o_read_data = latched word.
  - Go to IDLE unconditionally.
  - If i_read_en is still high in the following IDLE cycle, it is treated as a new request; this covers back-to-back loads.
- Read latency: o_read_vd rises exactly READ_LAT cycles after the first IDLE cycle that sampled i_read_en=1.
- o_read_data is 0 whenever o_read_vd=0.
- Writes:
  - When i_write_en=1 and i_read_en=0, the write commits to the array on that clock edge in any state.
  - Out-of-range writes are dropped and set o_err.
- Simultaneous i_read_en=1 and i_write_en=1:
  - The write is dropped and o_err is set.
  - The read proceeds normally.
- Write followed by a read of the same word: the read returns the new data, because the array is written before the next IDLE sample.
- o_err:
  - Set on any error condition.
  - Cleared by i_err_clr.
  - If set and clear coincide, set wins.
- Reset asserted mid-read: asynchronously back to IDLE, o_read_vd=0, no pending pulse after reset release.

Test Plan:
- READ_LAT=2: write 0xDEADBEEF to addr 0x10, then hold read_en with addr 0x10 -> o_read_vd pulses exactly 2 cycles after the first read cycle, o_read_data=0xDEADBEEF, o_err=0.
- Back-to-back loads: hold read_en across 0x20 (data 0x11111111) then 0x24 (data 0x22222222), with the address switching the cycle after the first pulse -> two pulses spaced READ_LAT+1 cycles apart, returning 0x11111111 then 0x22222222.
- Abort: read_en high for 1 cycle with READ_LAT=4, then low -> no o_read_vd pulse, state IDLE, o_busy=0 within 1 cycle.
- Out-of-range read at DEPTH*4 -> o_read_data=0 during the pulse, o_err=1; o_err stays 1 until an i_err_clr pulse, then 0.
- Simultaneous read_en and write_en at 0x8 with write data 0xAAAA5555 (prior content 0x12345678) -> read returns 0x12345678, o_err=1, and a later read still returns 0x12345678.
- Assert rst during WAIT, release 2 cycles later with read_en low -> o_read_vd stays 0 throughout, o_busy=0; array data written before reset is still readable.
